// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex blink display:
// segment codes, frame geometry and FSM states.
package hex_disp_pkg;

  localparam int NUM_DIGITS = 16;
  localparam int FRAME_BITS = 128;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to 7-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational.
module hex_to_seg
  import hex_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the segment code
  always_comb begin
    seg = SEG_0;
    unique case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/hex_blink_display.sv
// Blink generator plus serial 7-segment frame
// transmitter for the labkit display chain.
module hex_blink_display
  import hex_disp_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int BLINK_HALF = 13500000,
  parameter int FRAME_GAP  = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] data_in,
  input  logic [15:0] blink_fo_data,
  input  logic [15:0] blank_data,
  output logic        blink_fo,
  output logic        disp_clock,
  output logic        disp_data,
  output logic        disp_latch,
  output logic        frame_done
);

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW =
    (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam int BW =
    (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(FRAME_GAP - 1);
  localparam logic [BW-1:0] BLINK_LAST =
    BW'(BLINK_HALF - 1);
  localparam logic [6:0] BIT_LAST =
    7'(FRAME_BITS - 1);

  logic [BW-1:0] blink_cnt;

  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [6:0] bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic clk_d, data_d, latch_d, done_d;

  logic [NUM_DIGITS-1:0][6:0] seg_w;
  logic [FRAME_BITS-1:0] frame;

  // Byte i of the frame carries digit i, so
  // digit 15 sits at the MSB end and goes first.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    hex_to_seg u_seg (
      .hex (data_in[4*i +: 4]),
      .seg (seg_w[i])
    );
    assign frame[8*i +: 8] =
      (blank_data[i] |
       (blink_fo_data[i] & ~blink_fo)) ?
      8'h00 : {1'b0, seg_w[i]};
  end

  // Free-running blink square wave
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_fo  <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_fo  <= ~blink_fo;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Next state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = LOAD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      LOAD: begin
        shift_d = frame;
        bit_d   = '0;
        div_d   = '0;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    clk_d   = (state_d == SHIFT_HI);
    data_d  = (state_d inside {SHIFT_LO, SHIFT_HI}) ?
              shift_d[FRAME_BITS-1] : 1'b0;
    latch_d = (state_d == LATCH);
    done_d  = (state_d == LATCH) &&
              (div_d == DIV_LAST);
  end

  // State register; outputs come from flops so
  // disp_clock cannot glitch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      gap_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      disp_clock <= 1'b0;
      disp_data  <= 1'b0;
      disp_latch <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      disp_clock <= clk_d;
      disp_data  <= data_d;
      disp_latch <= latch_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_hex_blink_display.sv
// Directed-vector bench for hex_blink_display
// with a serial-frame capture monitor.
module tb_hex_blink_display;

  localparam int CLK_DIV    = 2;
  localparam int BLINK_HALF = 16;
  localparam int FRAME_GAP  = 8;
  localparam int PERIOD =
    1 + 256*CLK_DIV + CLK_DIV + FRAME_GAP;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] data_in = '0;
  logic [15:0] blink_fo_data = '0;
  logic [15:0] blank_data = '0;
  logic        blink_fo;
  logic        disp_clock;
  logic        disp_data;
  logic        disp_latch;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  int edges;
  int frames = 0;
  int nbits = 0;
  int last_nbits = 0;
  int done_edge = 0;
  logic prev_clk = 1'b0;
  logic [127:0] cap = '0;
  logic [127:0] last_frame = '0;

  hex_blink_display #(
    .CLK_DIV    (CLK_DIV),
    .BLINK_HALF (BLINK_HALF),
    .FRAME_GAP  (FRAME_GAP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .blink_fo_data (blink_fo_data),
    .blank_data    (blank_data),
    .blink_fo      (blink_fo),
    .disp_clock    (disp_clock),
    .disp_data     (disp_data),
    .disp_latch    (disp_latch),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  // Receiver model: shift on disp_clock rise
  always @(negedge clk) begin
    if (!reset_n) begin
      nbits    = 0;
      prev_clk = 1'b0;
    end else begin
      if (disp_clock && !prev_clk) begin
        cap   = {cap[126:0], disp_data};
        nbits = nbits + 1;
      end
      prev_clk = disp_clock;
      if (frame_done) begin
        last_frame = cap;
        last_nbits = nbits;
        done_edge  = edges;
        nbits      = 0;
        frames     = frames + 1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_frame(input string tag);
    int f0;
    int n;
    f0 = frames;
    n  = 0;
    while (frames == f0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (frames == f0) begin
      miscompares++;
      $display("FAIL %s: no frame_done in %0d cycles",
               tag, n);
    end
  endtask

  task automatic test_reset();
    int first_rise;
    int first_done;
    data_in = 64'h0123_4567_89AB_CDEF;
    blink_fo_data = '0;
    blank_data = '0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({blink_fo, disp_clock, disp_data,
         disp_latch, frame_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got %b want 00000",
               {blink_fo, disp_clock, disp_data,
                disp_latch, frame_done});
    end
    reset_n = 1'b1;
    first_rise = -1;
    first_done = -1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk);
      #1;
      if (first_rise < 0 && disp_clock)
        first_rise = n;
      if (first_done < 0 && frame_done)
        first_done = n;
      if (n == 521) begin
        vectors++;
        if ({disp_latch, disp_clock, disp_data}
            !== 3'b100) begin
          miscompares++;
          $display("FAIL latch_phase: got %b want 100",
                   {disp_latch, disp_clock, disp_data});
        end
      end
      if (n == 523) begin
        vectors++;
        if ({frame_done, disp_latch} !== 2'b00) begin
          miscompares++;
          $display("FAIL done_width: got %b want 00",
                   {frame_done, disp_latch});
        end
      end
    end
    vectors++;
    if (first_rise !== 11) begin
      miscompares++;
      $display("FAIL first_rise: got %0d want 11",
               first_rise);
    end
    vectors++;
    if (first_done !== 522) begin
      miscompares++;
      $display("FAIL first_done: got %0d want 522",
               first_done);
    end
  endtask

  task automatic test_basic();
    logic [127:0] exp;
    data_in = 64'h0123_4567_89AB_CDEF;
    blink_fo_data = '0;
    blank_data = '0;
    do_reset();
    wait_frame("basic");
    exp = 128'h3F065B4F_666D7D07_7F6F777C_395E7971;
    vectors++;
    if (last_frame !== exp) begin
      miscompares++;
      $display("FAIL basic_frame: got %h want %h",
               last_frame, exp);
    end
    vectors++;
    if (last_nbits !== 128) begin
      miscompares++;
      $display("FAIL basic_bits: got %0d want 128",
               last_nbits);
    end
    data_in = 64'hFEDC_BA98_7654_3210;
    wait_frame("basic_rev");
    exp = 128'h71795E39_7C776F7F_077D6D66_4F5B063F;
    vectors++;
    if (last_frame !== exp) begin
      miscompares++;
      $display("FAIL rev_frame: got %h want %h",
               last_frame, exp);
    end
  endtask

  task automatic test_blank();
    int f0;
    data_in = 64'h0123_4567_89AB_CDEF;
    blink_fo_data = '0;
    blank_data = 16'hFFFF;
    do_reset();
    wait_frame("blank");
    vectors++;
    if (last_frame !== 128'h0) begin
      miscompares++;
      $display("FAIL blank_frame: got %h want 0",
               last_frame);
    end
    f0 = frames;
    repeat (2*PERIOD) @(negedge clk);
    #1;
    vectors++;
    if (frames - f0 !== 2) begin
      miscompares++;
      $display("FAIL blank_rate: got %0d want 2",
               frames - f0);
    end
    blank_data = '0;
  endtask

  task automatic test_blink();
    logic [127:0] exp;
    int f0;
    int k;
    int load_edge;
    data_in = '0;
    blink_fo_data = 16'h8000;
    blank_data = '0;
    do_reset();
    f0 = frames;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk);
      #1;
      if (n == 15 || n == 16 || n == 31 ||
          n == 32 || n == 48) begin
        vectors++;
        if (blink_fo !== 1'((n / BLINK_HALF) % 2)) begin
          miscompares++;
          $display("FAIL blink_wave@%0d: got %b want %b",
                   n, blink_fo,
                   1'((n / BLINK_HALF) % 2));
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      wait_frame("blink");
      k = frames - f0 - 1;
      load_edge = FRAME_GAP + k*PERIOD;
      exp = {((load_edge / BLINK_HALF) % 2 == 1) ?
             8'h3F : 8'h00, {15{8'h3F}}};
      vectors++;
      if (last_frame !== exp) begin
        miscompares++;
        $display("FAIL blink_frame%0d: got %h want %h",
                 k, last_frame, exp);
      end
    end
    blink_fo_data = '0;
  endtask

  task automatic test_mid_change();
    int n;
    data_in = '0;
    blink_fo_data = '0;
    blank_data = '0;
    do_reset();
    n = 0;
    while (nbits <= 20 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (nbits <= 20) begin
      miscompares++;
      $display("FAIL mid_wait: got %0d bits want >20",
               nbits);
    end
    data_in = {16{4'hF}};
    wait_frame("mid_cur");
    vectors++;
    if (last_frame !== {16{8'h3F}}) begin
      miscompares++;
      $display("FAIL mid_cur: got %h want %h",
               last_frame, {16{8'h3F}});
    end
    wait_frame("mid_next");
    vectors++;
    if (last_frame !== {16{8'h71}}) begin
      miscompares++;
      $display("FAIL mid_next: got %h want %h",
               last_frame, {16{8'h71}});
    end
  endtask

  task automatic test_async_reset();
    int n;
    int f0;
    data_in = 64'h0123_4567_89AB_CDEF;
    blink_fo_data = '0;
    blank_data = '0;
    do_reset();
    n = 0;
    while (nbits < 60 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (nbits !== 60) begin
      miscompares++;
      $display("FAIL ar_wait: got %0d bits want 60",
               nbits);
    end
    f0 = frames;
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({blink_fo, disp_clock, disp_data,
         disp_latch, frame_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL ar_outs: got %b want 00000",
               {blink_fo, disp_clock, disp_data,
                disp_latch, frame_done});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_frame("ar_frame");
    vectors++;
    if (frames - f0 !== 1 || done_edge !== 522) begin
      miscompares++;
      $display("FAIL ar_timing: got %0d/%0d want 1/522",
               frames - f0, done_edge);
    end
    vectors++;
    if (last_frame !==
        128'h3F065B4F_666D7D07_7F6F777C_395E7971 ||
        last_nbits !== 128) begin
      miscompares++;
      $display("FAIL ar_frame: got %h/%0d want full",
               last_frame, last_nbits);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_blink();
    test_mid_change();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
